mult_pipe_tree: RTL and testbench

MULT_PIPE_TREE -- requirements
Module: mult_pipe_tree

---
 rtl/mult_pipe_pkg.sv | 16 +
 rtl/mult_pipe_add_stage.sv | 37 +++
 rtl/mult_pipe_tree.sv | 103 ++++++++++
 tb/tb_mult_pipe_tree.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pipe_pkg.sv
// mult_pipe_pkg: shared latency, legality and tree-layout helpers for mult_pipe_tree.
package mult_pipe_pkg;
   function automatic bit width_ok(int w);
      return w >= 4 && w <= 32 && (w & (w - 1)) == 0;
   endfunction
   function automatic bit tag_ok(int t);
      return t >= 1 && t <= 16;
   endfunction
   function automatic int lat(int w);
      return 2 + $clog2(w);
   endfunction
   // Levels are packed back to back in one node array: level l starts here.
   function automatic int node_off(int w, int l);
      return 2 * w - 2 * (w >> l);
   endfunction
endpackage

// File: rtl/mult_pipe_add_stage.sv
// mult_pipe_add_stage: one adder-tree level, N operands to N/2 registered pairwise sums.
module mult_pipe_add_stage #(
   parameter int N     = 2,
   parameter int DW    = 16,
   parameter int TAG_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en_i,
   input  logic                  valid_i,
   input  logic [TAG_W-1:0]      tag_i,
   input  logic [N-1:0][DW-1:0]  data_i,
   output logic                  valid_o,
   output logic [TAG_W-1:0]      tag_o,
   output logic [N/2-1:0][DW-1:0] data_o
);
   logic [N/2-1:0][DW-1:0] sum_d, sum_q;
   logic                   valid_q;
   logic [TAG_W-1:0]       tag_q;
   always_comb begin
      sum_d = '0;
      for (int k = 0; k < N / 2; k++) sum_d[k] = data_i[2*k] + data_i[2*k+1];
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         sum_q   <= '0;
      end else if (en_i) begin
         valid_q <= valid_i;
         tag_q   <= tag_i;
         sum_q   <= sum_d;
      end
   assign valid_o = valid_q;
   assign tag_o   = tag_q;
   assign data_o  = sum_q;
endmodule

// File: rtl/mult_pipe_tree.sv
// mult_pipe_tree: pipelined signed/unsigned multiplier, input register, registered
// pairwise adder tree over WIDTH partial products, output register, valid/ready flow.
module mult_pipe_tree import mult_pipe_pkg::*; #(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_signed,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_prod,
   output logic [TAG_W-1:0]   out_tag
);
   localparam int PW = 2 * WIDTH;
   localparam int LV = $clog2(WIDTH);
   localparam int NN = 2 * WIDTH - 1;

   if (!width_ok(WIDTH) || !tag_ok(TAG_W)) begin : g_bad
      $error("mult_pipe_tree: illegal WIDTH or TAG_W");
   end

   logic                     adv;
   logic [PW-1:0]            a_d, a_q;
   logic [WIDTH-1:0]         b_d, b_q;
   logic                     s_d, s_q, v_q;
   logic [TAG_W-1:0]         tag_d, tag_q, otag_d, otag_q;
   logic                     ov_q;
   logic [PW-1:0]            prod_d, prod_q;
   logic [WIDTH-1:0][PW-1:0] pp;
   wire  [NN-1:0][PW-1:0]    node;
   wire  [LV:0]              lv_v;
   wire  [LV:0][TAG_W-1:0]   lv_tag;

   assign adv      = !ov_q || out_ready;
   assign in_ready = adv;

   // Registers only load on adv, so in_valid here means the beat is accepted.
   always_comb begin
      a_d    = in_valid ? {{WIDTH{in_signed & in_a[WIDTH-1]}}, in_a} : a_q;
      b_d    = in_valid ? in_b : b_q;
      s_d    = in_valid ? in_signed : s_q;
      tag_d  = in_valid ? in_tag : tag_q;
      prod_d = lv_v[LV] ? node[NN-1] : '0;
      otag_d = lv_v[LV] ? lv_tag[LV] : '0;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         v_q    <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         s_q    <= 1'b0;
         tag_q  <= '0;
         ov_q   <= 1'b0;
         prod_q <= '0;
         otag_q <= '0;
      end else if (adv) begin
         v_q    <= in_valid;
         a_q    <= a_d;
         b_q    <= b_d;
         s_q    <= s_d;
         tag_q  <= tag_d;
         ov_q   <= lv_v[LV];
         prod_q <= prod_d;
         otag_q <= otag_d;
      end

   // The multiplier MSB carries negative weight for two's-complement operands.
   always_comb begin
      pp = '0;
      for (int i = 0; i < WIDTH; i++)
         pp[i] = !b_q[i] ? '0 : (s_q && i == WIDTH - 1) ? -(a_q << i) : (a_q << i);
   end

   assign node[WIDTH-1:0] = pp;
   assign lv_v[0]         = v_q;
   assign lv_tag[0]       = tag_q;

   for (genvar l = 0; l < LV; l++) begin : g_lvl
      localparam int N = WIDTH >> l;
      mult_pipe_add_stage #(.N(N), .DW(PW), .TAG_W(TAG_W)) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .en_i    (adv),
         .valid_i (lv_v[l]),
         .tag_i   (lv_tag[l]),
         .data_i  (node[node_off(WIDTH, l) +: N]),
         .valid_o (lv_v[l+1]),
         .tag_o   (lv_tag[l+1]),
         .data_o  (node[node_off(WIDTH, l + 1) +: N/2])
      );
   end

   assign out_valid = ov_q;
   assign out_prod  = prod_q;
   assign out_tag   = otag_q;
endmodule

// File: tb/tb_mult_pipe_tree.sv
// tb_mult_pipe_tree: directed WIDTH=8 scenarios plus randomized streams for
// WIDTH 4/8/16/32 scored against an arithmetic reference model.
module tb_mult_pipe_tree;
   import mult_pipe_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] msk(int w);
      return w >= 64 ? '1 : (64'd1 << w) - 64'd1;
   endfunction

   function automatic logic [63:0] ref_mul(int w, bit s, logic [63:0] a, logic [63:0] b);
      logic [63:0] ae, be;
      ae = a & msk(w);
      be = b & msk(w);
      if (s && ae[w-1]) ae = ae | ~msk(w);
      if (s && be[w-1]) be = be | ~msk(w);
      return (ae * be) & msk(2 * w);
   endfunction

   logic        rst8, rstg, iv8, ir8, s8, ov8, or8;
   logic [7:0]  a8, b8;
   logic [3:0]  t8, ot8;
   logic [15:0] op8;
   logic [15:0] ep[$];
   logic [3:0]  et[$];

   mult_pipe_tree #(.WIDTH(8), .TAG_W(4)) dut8 (
      .clk(clk), .rst_n(rst8), .in_valid(iv8), .in_ready(ir8), .in_signed(s8),
      .in_a(a8), .in_b(b8), .in_tag(t8), .out_valid(ov8), .out_ready(or8),
      .out_prod(op8), .out_tag(ot8)
   );

   for (genvar g = 0; g < 4; g++) begin : g_rnd
      localparam int W  = 4 << g;
      localparam int TW = g == 0 ? 3 : g == 1 ? 4 : g == 2 ? 8 : 16;
      logic            iv, ir, s, ov, orr, hv, got1, done;
      logic [W-1:0]    a, b;
      logic [TW-1:0]   t, ot, ht;
      logic [2*W-1:0]  op, hp;
      logic [63:0]     fp;
      logic [63:0]     qp[$];
      logic [15:0]     qt[$];

      mult_pipe_tree #(.WIDTH(W), .TAG_W(TW)) dut (
         .clk(clk), .rst_n(rstg), .in_valid(iv), .in_ready(ir), .in_signed(s),
         .in_a(a), .in_b(b), .in_tag(t), .out_valid(ov), .out_ready(orr),
         .out_prod(op), .out_tag(ot)
      );

      initial begin
         done = 1'b0; got1 = 1'b0; hv = 1'b0; fp = '0; hp = '0; ht = '0;
         iv = 1'b0; orr = 1'b1; s = 1'b0; a = '0; b = '0; t = '0;
         wait (rstg);
         for (int n = 0; n < 500 + 10 * lat(W); n++) begin
            @(negedge clk);
            orr = n >= 500 || ($urandom_range(3) != 0);
            iv  = n < 480 && (n < 3 || $urandom_range(3) != 0);
            a = W'($urandom); b = W'($urandom); s = 1'($urandom); t = TW'($urandom);
            if (n == 0) begin a = W'(1) << (W - 1); b = W'(1); s = 1'b1; end
            if (n == 1) begin a = '1; b = '1; s = 1'b0; end
            if (n == 2) begin a = W'(1) << (W - 1); b = a; s = 1'b1; end
            #1;
            if (hv) begin
               chk($sformatf("w%0d_hold_valid", W), ov, 1);
               chk($sformatf("w%0d_hold_prod", W), op, hp);
               chk($sformatf("w%0d_hold_tag", W), ot, ht);
            end
            if (!ov) begin
               chk($sformatf("w%0d_idle_prod", W), op, 0);
               chk($sformatf("w%0d_idle_tag", W), ot, 0);
            end
            if (iv && ir) begin
               qp.push_back(ref_mul(W, s, a, b));
               qt.push_back(16'(t));
            end
            if (ov && orr) begin
               if (qp.size() == 0) chk($sformatf("w%0d_spurious", W), 1, 0);
               else begin
                  if (!got1) begin fp = op; got1 = 1'b1; end
                  chk($sformatf("w%0d_prod", W), op, qp.pop_front());
                  chk($sformatf("w%0d_tag", W), ot, qt.pop_front());
               end
            end
            hv = ov && !orr; hp = op; ht = ot;
         end
         chk($sformatf("w%0d_drain", W), qp.size(), 0);
         done = 1'b1;
      end
   end

   task automatic one(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [3:0] t, input logic [15:0] exp_p, input string nm);
      int n;
      @(negedge clk);
      a8 = a; b8 = b; s8 = s; t8 = t; iv8 = 1'b1; or8 = 1'b1;
      @(negedge clk);
      iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom); t8 = 4'($urandom);
      n = 1;
      while (!ov8 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_lat"}, n, 5);
      chk({nm, "_prod"}, op8, exp_p);
      chk({nm, "_tag"}, ot8, t);
      @(negedge clk);
      chk({nm, "_once"}, ov8, 0);
   endtask

   task automatic stream(input int nb, input int st, output int ndel, output int span);
      int sent, hs, first, last;
      logic [15:0] hp;
      logic [3:0]  ht;
      sent = 0; hs = 0; first = -1; last = -1; hp = '0; ht = '0; ndel = 0;
      for (int n = 0; n < 60 && ndel < nb; n++) begin
         @(negedge clk);
         or8 = !(ov8 && hs < st);
         if (!or8) hs++;
         iv8 = sent < nb;
         a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom); t8 = 4'(sent);
         #1;
         if (!or8) begin
            chk("stall_rdy", ir8, 0);
            if (hs > 1) begin
               chk("stall_prod", op8, hp);
               chk("stall_tag", ot8, ht);
            end
            hp = op8; ht = ot8;
         end
         if (iv8 && ir8) begin
            ep.push_back(16'(ref_mul(8, s8, a8, b8)));
            et.push_back(t8);
            sent++;
         end
         if (ov8 && or8) begin
            if (ep.size() == 0) chk("strm_spurious", 1, 0);
            else begin
               chk("strm_prod", op8, ep.pop_front());
               chk("strm_tag", ot8, et.pop_front());
            end
            if (first < 0) first = n;
            last = n;
            ndel++;
         end
      end
      iv8 = 1'b0; or8 = 1'b1;
      span = last - first + 1;
   endtask

   initial begin
      int nd, sp;
      rst8 = 1'b0; rstg = 1'b0; iv8 = 1'b0; or8 = 1'b1;
      a8 = '0; b8 = '0; s8 = 1'b0; t8 = '0;
      repeat (3) @(negedge clk);
      chk("rst_valid", ov8, 0);
      chk("rst_prod", op8, 0);
      chk("rst_tag", ot8, 0);
      rst8 = 1'b1; rstg = 1'b1; or8 = 1'b0;
      @(negedge clk);
      chk("rdy_after_rst", ir8, 1);
      or8 = 1'b1;

      one(8'hFF, 8'hFF, 1'b0, 4'd3, 16'hFE01, "u_ff_ff");
      one(8'h80, 8'h80, 1'b1, 4'd5, 16'h4000, "s_80_80");
      one(8'hFF, 8'h7F, 1'b1, 4'd6, 16'hFF81, "s_ff_7f");
      one(8'hFF, 8'h7F, 1'b0, 4'd7, 16'h7E81, "u_ff_7f");

      stream(8, 0, nd, sp);
      chk("b2b_count", nd, 8);
      chk("b2b_span", sp, 8);
      @(negedge clk);
      chk("b2b_tail", ov8, 0);

      stream(6, 3, nd, sp);
      chk("stall_count", nd, 6);
      @(negedge clk);
      chk("stall_tail", ov8, 0);

      @(negedge clk);
      iv8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b0; t8 = 4'd9; or8 = 1'b0;
      @(negedge clk);
      iv8 = 1'b0;
      for (int k = 0; k < 20 && !ov8; k++) @(negedge clk);
      chk("pre_rst_valid", ov8, 1);
      rst8 = 1'b0;
      #1;
      chk("async_valid", ov8, 0);
      chk("async_prod", op8, 0);
      chk("async_tag", ot8, 0);
      @(negedge clk);
      rst8 = 1'b1; or8 = 1'b1;

      @(negedge clk);
      iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); t8 = 4'd1;
      @(negedge clk);
      t8 = 4'd2;
      @(negedge clk);
      iv8 = 1'b0;
      @(negedge clk);
      rst8 = 1'b0;
      @(negedge clk);
      rst8 = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("post_rst_valid", ov8, 0);
      end
      one(8'd3, 8'd5, 1'b0, 4'd4, 16'h000F, "rst_new");

      for (int k = 0; k < 3000 && !(g_rnd[0].done && g_rnd[1].done && g_rnd[2].done && g_rnd[3].done); k++)
         @(negedge clk);
      chk("rnd_done", g_rnd[0].done && g_rnd[1].done && g_rnd[2].done && g_rnd[3].done, 1);
      chk("w16_corner", g_rnd[2].fp, 64'hFFFF8000);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
